// File: rtl/ysyx_pc_fetch_if.sv
// Signal bundle between the fetch stage and its neighbours: instruction memory,
// decode, and the execute-stage control-transfer resolution.
interface ysyx_pc_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        ex_ctl_valid;
  logic [1:0]  ex_ctl_kind;
  logic        BrE;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        redirect_misalign;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst, redirect_misalign,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  ex_ctl_valid, ex_ctl_kind, BrE, ex_pc, ex_imm, ex_rs1
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst, redirect_misalign,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output ex_ctl_valid, ex_ctl_kind, BrE, ex_pc, ex_imm, ex_rs1
  );
endinterface

// File: rtl/ysyx_pc_fetch.sv
// PC register and single-outstanding instruction fetch stage; redirects from
// execute override any same-cycle handshake and stale responses are dropped.
module ysyx_pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic           clk,
  input logic           rst_n,
  ysyx_pc_fetch_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  function automatic logic [31:0] calc_target(
    input logic [1:0]         kind,
    input logic [31:0]        pc_in,
    input logic signed [31:0] imm,
    input logic [31:0]        rs1
  );
    logic [31:0] sum;
    if (kind == 2'b10) begin
      sum = rs1 + imm;
      sum = sum & ~32'h1;
    end else begin
      sum = pc_in + imm;
    end
    return sum;
  endfunction

  logic [2:0]  state;
  logic [31:0] pc;
  logic [31:0] id_pc_r;
  logic [31:0] id_inst_r;
  logic        misalign_r;
  logic        redirect;
  logic [31:0] target;

  always_comb begin
    redirect = bus.ex_ctl_valid &
               (((bus.ex_ctl_kind == 2'b00) & bus.BrE) |
                (bus.ex_ctl_kind == 2'b01) |
                (bus.ex_ctl_kind == 2'b10));
    target   = calc_target(bus.ex_ctl_kind, bus.ex_pc, bus.ex_imm, bus.ex_rs1);
  end

  assign bus.imem_req_valid    = (state == S_REQ) & ~redirect;
  assign bus.imem_req_addr     = pc;
  assign bus.id_valid          = (state == S_HOLD) & ~redirect;
  assign bus.id_pc             = id_pc_r;
  assign bus.id_inst           = id_inst_r;
  assign bus.redirect_misalign = misalign_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      id_pc_r    <= 32'h0;
      id_inst_r  <= 32'h0;
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= redirect & (target[1:0] != 2'b00);
      case (state)
        S_IDLE: begin
          if (redirect) pc <= target;
          state <= S_REQ;
        end
        S_REQ: begin
          if (redirect) pc <= target;
          else if (bus.imem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (redirect) begin
            pc    <= target;
            state <= bus.imem_rsp_valid ? S_REQ : S_DROP;
          end else if (bus.imem_rsp_valid) begin
            id_inst_r <= bus.imem_rsp_data;
            id_pc_r   <= pc;
            state     <= S_HOLD;
          end
        end
        // The response for the abandoned request is still owed; swallow it.
        S_DROP: begin
          if (redirect) pc <= target;
          if (bus.imem_rsp_valid) state <= S_REQ;
        end
        S_HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= S_REQ;
          end else if (bus.id_ready) begin
            pc    <= pc + 32'd4;
            state <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_pc_fetch.sv
// Directed scenarios plus a randomized run checked against a transaction-level
// model of the fetch stream (expected next address, stale tracking, memory image).
module tb_ysyx_pc_fetch;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  ysyx_pc_fetch_if bus ();
  ysyx_pc_fetch #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.id_ready       = 1'b0;
    bus.ex_ctl_valid   = 1'b0;
    bus.ex_ctl_kind    = 2'b00;
    bus.BrE            = 1'b0;
    bus.ex_pc          = 32'h0;
    bus.ex_imm         = 32'h0;
    bus.ex_rs1         = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", bus.imem_req_valid); end
    total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL rst_id_valid got=%b exp=0", bus.id_valid); end
    total++; if (bus.id_pc !== 32'h0) begin bad++; $display("FAIL rst_id_pc got=%h exp=0", bus.id_pc); end
    total++; if (bus.id_inst !== 32'h0) begin bad++; $display("FAIL rst_id_inst got=%h exp=0", bus.id_inst); end
    total++; if (bus.redirect_misalign !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%b exp=0", bus.redirect_misalign); end
    rst_n = 1'b1;
    #1;
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL idle_req_valid got=%b exp=0", bus.imem_req_valid); end
    tick(); #1;
    total++; if (bus.imem_req_valid !== 1'b1) begin bad++; $display("FAIL first_req_valid got=%b exp=1", bus.imem_req_valid); end
    total++; if (bus.imem_req_addr !== RST_PC) begin bad++; $display("FAIL first_req_addr got=%h exp=%h", bus.imem_req_addr, RST_PC); end
  endtask

  task automatic test_basic_fetch();
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0013;
    #1;
    total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL basic_wait_id_valid got=%b exp=0", bus.id_valid); end
    tick();
    bus.imem_rsp_valid = 1'b0; bus.id_ready = 1'b1;
    #1;
    total++; if (bus.id_valid !== 1'b1) begin bad++; $display("FAIL basic_id_valid got=%b exp=1", bus.id_valid); end
    total++; if (bus.id_pc !== 32'h8000_0000) begin bad++; $display("FAIL basic_id_pc got=%h exp=80000000", bus.id_pc); end
    total++; if (bus.id_inst !== 32'h0000_0013) begin bad++; $display("FAIL basic_id_inst got=%h exp=00000013", bus.id_inst); end
    tick();
    bus.id_ready = 1'b0;
    #1;
    total++; if (bus.imem_req_addr !== 32'h8000_0004 || bus.imem_req_valid !== 1'b1) begin bad++; $display("FAIL basic_next_req got=%h/%b exp=80000004/1", bus.imem_req_addr, bus.imem_req_valid); end
  endtask

  task automatic test_branch_in_hold();
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0063;
    tick();
    bus.imem_rsp_valid = 1'b0;
    bus.ex_ctl_valid = 1'b1; bus.ex_ctl_kind = 2'b00; bus.BrE = 1'b1;
    bus.ex_pc = 32'h8000_0010; bus.ex_imm = 32'hFFFF_FFF8;
    bus.id_ready = 1'b1;
    #1;
    total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL br_hold_id_valid got=%b exp=0", bus.id_valid); end
    tick();
    clear_inputs();
    #1;
    total++; if (bus.imem_req_addr !== 32'h8000_0008 || bus.imem_req_valid !== 1'b1) begin bad++; $display("FAIL br_hold_req got=%h/%b exp=80000008/1", bus.imem_req_addr, bus.imem_req_valid); end
  endtask

  task automatic test_jalr_drop();
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.ex_ctl_valid = 1'b1; bus.ex_ctl_kind = 2'b10;
    bus.ex_rs1 = 32'h8000_0101; bus.ex_imm = 32'h0000_0004;
    tick();
    clear_inputs();
    #1;
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL drop_req_valid got=%b exp=0", bus.imem_req_valid); end
    total++; if (bus.redirect_misalign !== 1'b0) begin bad++; $display("FAIL drop_misalign got=%b exp=0", bus.redirect_misalign); end
    tick();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF;
    #1;
    total++; if (bus.id_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL drop_stale_rsp got=%b/%b exp=0/0", bus.id_valid, bus.imem_req_valid); end
    tick();
    bus.imem_rsp_valid = 1'b0;
    #1;
    total++; if (bus.imem_req_addr !== 32'h8000_0104 || bus.imem_req_valid !== 1'b1) begin bad++; $display("FAIL drop_next_req got=%h/%b exp=80000104/1", bus.imem_req_addr, bus.imem_req_valid); end
    total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL drop_no_id got=%b exp=0", bus.id_valid); end
  endtask

  task automatic test_no_redirect();
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.ex_ctl_valid = 1'b1; bus.ex_ctl_kind = 2'b00; bus.BrE = 1'b0; bus.ex_imm = 32'h100;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0033;
    tick();
    bus.imem_rsp_valid = 1'b0;
    bus.ex_ctl_valid = 1'b1; bus.ex_ctl_kind = 2'b11; bus.BrE = 1'b1;
    bus.ex_pc = 32'h100; bus.ex_imm = 32'h100; bus.id_ready = 1'b1;
    #1;
    total++; if (bus.id_valid !== 1'b1) begin bad++; $display("FAIL norr_id_valid got=%b exp=1", bus.id_valid); end
    total++; if (bus.id_pc !== 32'h8000_0104 || bus.id_inst !== 32'h0000_0033) begin bad++; $display("FAIL norr_id got=%h/%h exp=80000104/00000033", bus.id_pc, bus.id_inst); end
    tick();
    clear_inputs();
    #1;
    total++; if (bus.imem_req_addr !== 32'h8000_0108 || bus.imem_req_valid !== 1'b1) begin bad++; $display("FAIL norr_next_req got=%h/%b exp=80000108/1", bus.imem_req_addr, bus.imem_req_valid); end
  endtask

  task automatic test_stall();
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hABCD_1234;
    tick();
    bus.imem_rsp_valid = 1'b0; bus.id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (bus.id_valid !== 1'b1 || bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_valids c%0d got=%b/%b exp=1/0", i, bus.id_valid, bus.imem_req_valid); end
      total++; if (bus.id_pc !== 32'h8000_0108 || bus.id_inst !== 32'hABCD_1234) begin bad++; $display("FAIL stall_data c%0d got=%h/%h exp=80000108/abcd1234", i, bus.id_pc, bus.id_inst); end
      tick();
    end
    bus.id_ready = 1'b1;
    tick();
    bus.id_ready = 1'b0;
    #1;
    total++; if (bus.imem_req_addr !== 32'h8000_010C || bus.imem_req_valid !== 1'b1) begin bad++; $display("FAIL stall_next_req got=%h/%b exp=8000010c/1", bus.imem_req_addr, bus.imem_req_valid); end
  endtask

  task automatic test_jal_wrap_misalign();
    bus.imem_req_ready = 1'b1;
    bus.ex_ctl_valid = 1'b1; bus.ex_ctl_kind = 2'b01;
    bus.ex_pc = 32'hFFFF_FFFC; bus.ex_imm = 32'h0000_0008;
    #1;
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL jal_req_suppressed got=%b exp=0", bus.imem_req_valid); end
    tick();
    clear_inputs();
    #1;
    total++; if (bus.imem_req_addr !== 32'h0000_0004 || bus.imem_req_valid !== 1'b1) begin bad++; $display("FAIL jal_wrap_req got=%h/%b exp=00000004/1", bus.imem_req_addr, bus.imem_req_valid); end
    total++; if (bus.redirect_misalign !== 1'b0) begin bad++; $display("FAIL jal_wrap_misalign got=%b exp=0", bus.redirect_misalign); end
    bus.ex_ctl_valid = 1'b1; bus.ex_ctl_kind = 2'b01;
    bus.ex_pc = 32'h8000_0000; bus.ex_imm = 32'h0000_0002;
    tick();
    clear_inputs();
    #1;
    total++; if (bus.imem_req_addr !== 32'h8000_0002) begin bad++; $display("FAIL jal_mis_req got=%h exp=80000002", bus.imem_req_addr); end
    total++; if (bus.redirect_misalign !== 1'b1) begin bad++; $display("FAIL jal_mis_pulse got=%b exp=1", bus.redirect_misalign); end
    tick(); #1;
    total++; if (bus.redirect_misalign !== 1'b0) begin bad++; $display("FAIL jal_mis_clear got=%b exp=0", bus.redirect_misalign); end
  endtask

  task automatic test_mid_reset();
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0077;
    tick();
    bus.imem_rsp_valid = 1'b0;
    #1;
    total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h8000_0002) begin bad++; $display("FAIL mrst_pre got=%b/%h exp=1/80000002", bus.id_valid, bus.id_pc); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.id_valid !== 1'b0 || bus.id_pc !== 32'h0 || bus.id_inst !== 32'h0) begin bad++; $display("FAIL mrst_async got=%b/%h/%h exp=0/0/0", bus.id_valid, bus.id_pc, bus.id_inst); end
    tick();
    rst_n = 1'b1;
    tick();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0055;
    #1;
    total++; if (bus.imem_req_addr !== RST_PC || bus.imem_req_valid !== 1'b1) begin bad++; $display("FAIL mrst_req got=%h/%b exp=80000000/1", bus.imem_req_addr, bus.imem_req_valid); end
    tick();
    bus.imem_rsp_valid = 1'b0;
    #1;
    total++; if (bus.imem_req_valid !== 1'b1 || bus.id_valid !== 1'b0 || bus.imem_req_addr !== RST_PC) begin bad++; $display("FAIL mrst_ignore_rsp got=%b/%b/%h exp=1/0/80000000", bus.imem_req_valid, bus.id_valid, bus.imem_req_addr); end
  endtask

  task automatic test_random();
    logic [31:0] exp_next, last_addr, tgt;
    logic        outstanding, stale, redir, prev_mis;
    int          delay, delivered;
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_next = RST_PC; last_addr = 32'h0; outstanding = 1'b0; stale = 1'b0;
    prev_mis = 1'b0; delay = 0; delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.imem_rsp_valid = 1'b0;
      if (outstanding) begin
        if (delay == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mem_word(last_addr);
          outstanding = 1'b0;
        end else begin
          delay--;
        end
      end
      bus.imem_req_ready = 1'($urandom_range(0, 1));
      bus.id_ready       = ($urandom_range(0, 3) != 0);
      bus.ex_ctl_valid   = ($urandom_range(0, 9) == 0);
      bus.ex_ctl_kind    = 2'($urandom_range(0, 3));
      bus.BrE            = 1'($urandom_range(0, 1));
      bus.ex_pc          = $urandom & 32'hFFFF_FFFC;
      bus.ex_rs1         = $urandom;
      bus.ex_imm         = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      redir = bus.ex_ctl_valid & (((bus.ex_ctl_kind == 2'b00) & bus.BrE) |
                                  (bus.ex_ctl_kind == 2'b01) | (bus.ex_ctl_kind == 2'b10));
      tgt = (bus.ex_ctl_kind == 2'b10) ? ((bus.ex_rs1 + bus.ex_imm) & 32'hFFFF_FFFE)
                                       : (bus.ex_pc + bus.ex_imm);
      #1;
      total++; if (bus.redirect_misalign !== prev_mis) begin bad++; $display("FAIL rnd_misalign c%0d got=%b exp=%b", cyc, bus.redirect_misalign, prev_mis); end
      if (bus.imem_req_valid === 1'b1) begin
        total++; if (outstanding || redir) begin bad++; $display("FAIL rnd_req_excl c%0d got=1 exp=0 (out=%b redir=%b)", cyc, outstanding, redir); end
      end
      if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready) begin
        total++; if (bus.imem_req_addr !== exp_next) begin bad++; $display("FAIL rnd_req_addr c%0d got=%h exp=%h", cyc, bus.imem_req_addr, exp_next); end
        outstanding = 1'b1; last_addr = bus.imem_req_addr; stale = 1'b0;
        delay = $urandom_range(0, 2);
      end
      if (bus.id_valid === 1'b1) begin
        total++; if (stale || redir) begin bad++; $display("FAIL rnd_id_stale c%0d got=1 exp=0", cyc); end
        total++; if (bus.id_pc !== last_addr) begin bad++; $display("FAIL rnd_id_pc c%0d got=%h exp=%h", cyc, bus.id_pc, last_addr); end
        total++; if (bus.id_inst !== mem_word(last_addr)) begin bad++; $display("FAIL rnd_id_inst c%0d got=%h exp=%h", cyc, bus.id_inst, mem_word(last_addr)); end
        if (bus.id_ready) begin
          exp_next = last_addr + 32'd4;
          delivered++;
        end
      end
      if (redir) begin
        exp_next = tgt;
        stale = 1'b1;
      end
      prev_mis = redir & (tgt[1:0] != 2'b00);
      tick();
    end
    total++; if (delivered < 100) begin bad++; $display("FAIL rnd_throughput got=%0d exp>=100", delivered); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_branch_in_hold();
    test_jalr_drop();
    test_no_redirect();
    test_stall();
    test_jal_wrap_misalign();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
